// File: rtl/jtframe_romcache.sv
// jtframe_romcache: small fully-associative cache of 32-bit ROM words between
// a narrow demand port (DW = 8/16/32) and an SDRAM word port. Entries are
// replaced round-robin, which amounts to first-in first-out replacement.
// Optional feature: define JTFRAME_ROMCACHE_PREFETCH_EN to fetch the next
// word automatically after every demand fill.
module jtframe_romcache #(
  parameter int AW        = 18,
  parameter int DW        = 8,
  parameter int ENTRIES   = 4,
  parameter int INVERT_A0 = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic [AW-1:0] addr,
  input  logic          addr_ok,
  input  logic          flush,
  input  logic [31:0]   din,
  input  logic          din_ok,
  input  logic          we,
  output logic          req,
  output logic [AW-1:0] addr_req,
  output logic          data_ok,
  output logic [DW-1:0] dout
);
  // LW: number of address bits that select a lane inside a 32-bit word
  localparam int LW = (DW == 8) ? 2 : (DW == 16) ? 1 : 0;
  localparam int TW = AW - LW;
  localparam int PW = $clog2(ENTRIES);
  localparam logic [PW-1:0] LAST = PW'(ENTRIES - 1);

`ifdef JTFRAME_ROMCACHE_PREFETCH_EN
  typedef enum logic [1:0] { IDLE, FETCH, PREFETCH } state_t;
`else
  typedef enum logic { IDLE, FETCH } state_t;
`endif
  state_t state, state_nx;

  logic [ENTRIES-1:0] valid;
  logic [TW-1:0]      tags  [ENTRIES];
  logic [31:0]        words [ENTRIES];
  logic [PW-1:0]      ptr;
  logic               flush_pend;

  logic [TW-1:0]      word_addr;
  logic [TW-1:0]      fill_tag;
  logic [ENTRIES-1:0] match;
  logic               hit;
  logic [31:0]        hit_word;
  logic [DW-1:0]      lane_data;
  logic               ack;
  logic               fill;
  logic               start;

  assign word_addr = addr[AW-1:LW];
  assign fill_tag  = addr_req[AW-1:LW];
  // an acknowledge only means something while a request is outstanding
  assign ack       = din_ok && we && (state != IDLE);
  // a flush seen at any point of the transfer makes the fetched word stale
  assign fill      = ack && !(flush || flush_pend);
  assign req       = (state != IDLE);

  // Tag lookup: at most one entry can match, so OR-ing the data is a mux
  always_comb begin
    match    = '0;
    hit_word = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      match[i] = valid[i] && (tags[i] == word_addr);
      if (match[i]) hit_word = hit_word | words[i];
    end
  end
  assign hit = |match;

  generate
    if (DW == 8) begin : g_lane8
      logic [1:0] sel;
      assign sel = {addr[1], addr[0] ^ (INVERT_A0 != 0)};
      // Byte lane select inside the hit word
      always_comb begin
        case (sel)
          2'd0:    lane_data = hit_word[7:0];
          2'd1:    lane_data = hit_word[15:8];
          2'd2:    lane_data = hit_word[23:16];
          default: lane_data = hit_word[31:24];
        endcase
      end
    end else if (DW == 16) begin : g_lane16
      assign lane_data = addr[0] ? hit_word[31:16] : hit_word[15:0];
    end else begin : g_lane32
      assign lane_data = hit_word;
    end
  endgenerate

`ifdef JTFRAME_ROMCACHE_PREFETCH_EN
  logic [TW-1:0] next_tag;
  logic          pf_cached;
  assign next_tag = fill_tag + 1'b1;
  // Next word already present, ignoring the entry the demand fill overwrites
  always_comb begin
    pf_cached = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid[i] && (tags[i] == next_tag) && (PW'(i) != ptr)) pf_cached = 1'b1;
    end
  end
`endif

  // Next-state logic for the SDRAM request FSM
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    case (state)
      IDLE: begin
        if (cen && addr_ok && !hit) begin
          state_nx = FETCH;
          start    = 1'b1;
        end
      end
      FETCH: begin
        if (ack) begin
`ifdef JTFRAME_ROMCACHE_PREFETCH_EN
          state_nx = (fill && !pf_cached) ? PREFETCH : IDLE;
`else
          state_nx = IDLE;
`endif
        end
      end
`ifdef JTFRAME_ROMCACHE_PREFETCH_EN
      PREFETCH: begin
        if (ack) state_nx = IDLE;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Control: valid bits, replacement pointer, request address, pending flush
  always_ff @(posedge clk) begin
    if (rst) begin
      valid      <= '0;
      ptr        <= '0;
      addr_req   <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (flush)     valid      <= '0;
      else if (fill) valid[ptr] <= 1'b1;
      if (fill) ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
      if (start) addr_req <= AW'(word_addr) << LW;
`ifdef JTFRAME_ROMCACHE_PREFETCH_EN
      else if ((state == FETCH) && (state_nx == PREFETCH)) addr_req <= AW'(next_tag) << LW;
`endif
      if (start)               flush_pend <= flush;
      else if (ack)            flush_pend <= 1'b0;
      else if (state != IDLE)  flush_pend <= flush_pend | flush;
    end
  end

  // Entry payload, written only by an accepted fill
  always_ff @(posedge clk) begin
    if (fill) begin
      tags[ptr]  <= fill_tag;
      words[ptr] <= din;
    end
  end

  // Demand side: one-cycle hit response, dout holds on misses
  always_ff @(posedge clk) begin
    if (rst) begin
      data_ok <= 1'b0;
      dout    <= '0;
    end else if (cen) begin
      data_ok <= addr_ok && hit;
      if (addr_ok && hit) dout <= lane_data;
    end
  end
endmodule

// File: tb/tb_jtframe_romcache.sv
// Bench for jtframe_romcache (default build, DW=8, ENTRIES=4). Two instances
// share all inputs and differ only in INVERT_A0. A FIFO-replacement model of
// the cache predicts every output each cycle; directed scenarios add literal
// expectations on top.
module tb_jtframe_romcache;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cen = 1'b0;
  logic          addr_ok = 1'b0;
  logic          flush = 1'b0;
  logic          din_ok = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [31:0]   din = '0;
  logic          req0, req1, ok0, ok1;
  logic [AW-1:0] areq0, areq1;
  logic [7:0]    dout0, dout1;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  jtframe_romcache #(.AW(AW), .DW(8), .ENTRIES(4), .INVERT_A0(0)) u_dut0 (
    .clk(clk), .rst(rst), .cen(cen), .addr(addr), .addr_ok(addr_ok), .flush(flush),
    .din(din), .din_ok(din_ok), .we(we), .req(req0), .addr_req(areq0),
    .data_ok(ok0), .dout(dout0));

  jtframe_romcache #(.AW(AW), .DW(8), .ENTRIES(4), .INVERT_A0(1)) u_dut1 (
    .clk(clk), .rst(rst), .cen(cen), .addr(addr), .addr_ok(addr_ok), .flush(flush),
    .din(din), .din_ok(din_ok), .we(we), .req(req1), .addr_req(areq1),
    .data_ok(ok1), .dout(dout1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed { logic [15:0] tag; logic [31:0] word; } ent_t;
  ent_t          cache_q[$];
  bit            busy, fpend;
  logic [15:0]   ftag;
  logic          exp_req = 1'b0, exp_ok = 1'b0;
  logic [AW-1:0] exp_areq = '0;
  logic [7:0]    exp_d0 = '0, exp_d1 = '0;

  function automatic logic [7:0] lane(input logic [31:0] w, input logic [AW-1:0] a, input bit inv);
    int sel;
    sel = 2 * int'(a[1]) + int'(a[0] ^ inv);
    return w[8*sel +: 8];
  endfunction

  always @(posedge clk) begin : model
    logic [15:0] wa;
    bit          mhit;
    logic [31:0] hw;
    ent_t        e;
    wa   = addr[AW-1:2];
    mhit = 1'b0;
    hw   = '0;
    foreach (cache_q[i]) if (cache_q[i].tag == wa) begin mhit = 1'b1; hw = cache_q[i].word; end
    if (rst) begin
      cache_q.delete();
      busy = 1'b0; fpend = 1'b0;
      exp_req = 1'b0; exp_areq = '0; exp_ok = 1'b0; exp_d0 = '0; exp_d1 = '0;
    end else begin
      if (cen) begin
        exp_ok = addr_ok && mhit;
        if (addr_ok && mhit) begin
          exp_d0 = lane(hw, addr, 1'b0);
          exp_d1 = lane(hw, addr, 1'b1);
        end
      end
      if (busy) begin
        if (din_ok && we) begin
          if (!(flush || fpend)) begin
            e.tag = ftag; e.word = din;
            cache_q.push_back(e);
            if (cache_q.size() > 4) void'(cache_q.pop_front());
          end
          busy = 1'b0;
        end else begin
          fpend = fpend | flush;
        end
      end else if (cen && addr_ok && !mhit) begin
        busy = 1'b1; ftag = wa; fpend = flush; exp_areq = {wa, 2'b00};
      end
      if (flush) cache_q.delete();
      exp_req = busy;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      chk("req0", 32'(req0), 32'(exp_req));
      chk("req1", 32'(req1), 32'(exp_req));
      chk("addr_req0", 32'(areq0), 32'(exp_areq));
      chk("addr_req1", 32'(areq1), 32'(exp_areq));
      chk("data_ok0", 32'(ok0), 32'(exp_ok));
      chk("data_ok1", 32'(ok1), 32'(exp_ok));
      chk("dout0", 32'(dout0), 32'(exp_d0));
      chk("dout1", 32'(dout1), 32'(exp_d1));
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_req();
    for (int n = 0; n < 20 && !req0; n++) @(negedge clk);
  endtask

  task automatic ack_cycle(input logic [31:0] d);
    din = d; din_ok = 1'b1; we = 1'b1;
    @(negedge clk);
    din_ok = 1'b0; we = 1'b0;
  endtask

  task automatic fill_word(input logic [AW-1:0] a, input logic [31:0] d);
    addr = a; addr_ok = 1'b1;
    @(negedge clk);
    wait_req();
    chk("fill_req", 32'(req0), 1);
    ack_cycle(d);
    addr_ok = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    chk("rst_req", 32'(req0), 0);
    chk("rst_data_ok", 32'(ok0), 0);
    chk("rst_dout", 32'(dout0), 0);
    chk("rst_addr_req", 32'(areq0), 0);

    // first miss, fill and byte lanes
    rst = 1'b0; cen = 1'b1; addr = 18'h00010; addr_ok = 1'b1;
    @(negedge clk);
    chk("miss_req", 32'(req0), 1);
    chk("miss_addr_req", 32'(areq0), 32'h10);
    ack_cycle(32'hDDCCBBAA);
    chk("fill_edge_req", 32'(req0), 0);
    chk("fill_edge_ok", 32'(ok0), 0);
    @(negedge clk);
    chk("hit_ok", 32'(ok0), 1);
    chk("hit_dout", 32'(dout0), 32'hAA);
    chk("hit_dout_inv", 32'(dout1), 32'hBB);
    addr = 18'h00013;
    @(negedge clk);
    chk("lane3_dout", 32'(dout0), 32'hDD);
    chk("lane3_dout_inv", 32'(dout1), 32'hCC);
    chk("lane3_req", 32'(req0), 0);

    // round-robin eviction of the oldest word
    addr_ok = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) fill_word(18'(k * 4), 32'h1000 + k);
    addr = 18'h4; addr_ok = 1'b1;
    @(negedge clk);
    chk("evict_keep_ok", 32'(ok0), 1);
    chk("evict_keep_req", 32'(req0), 0);
    addr = 18'h0;
    @(negedge clk);
    chk("evict_req", 32'(req0), 1);
    ack_cycle(32'h1000);
    addr_ok = 1'b0;
    @(negedge clk);

    // flush while fetching discards the fill
    addr = 18'h40; addr_ok = 1'b1;
    @(negedge clk);
    wait_req();
    chk("flush_req", 32'(req0), 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    ack_cycle(32'h55);
    @(negedge clk);
    chk("flush_rereq", 32'(req0), 1);
    chk("flush_ok", 32'(ok0), 0);
    ack_cycle(32'h55);
    addr_ok = 1'b0;
    @(negedge clk);

    // reset in the middle of a fetch; late acknowledge ignored
    addr = 18'h80; addr_ok = 1'b1;
    @(negedge clk);
    wait_req();
    chk("rstmid_req", 32'(req0), 1);
    rst = 1'b1; addr_ok = 1'b0;
    @(negedge clk);
    chk("rstmid_req_drop", 32'(req0), 0);
    rst = 1'b0;
    ack_cycle(32'h77);
    chk("late_ack_req", 32'(req0), 0);
    addr_ok = 1'b1;
    @(negedge clk);
    chk("late_ack_rereq", 32'(req0), 1);
    chk("late_ack_ok", 32'(ok0), 0);
    ack_cycle(32'h77);
    addr_ok = 1'b0;
    @(negedge clk);

    // no prefetch in the default build; cen gates the demand side
    fill_word(18'h400, 32'hCAFEBABE);
    repeat (3) @(negedge clk);
    chk("no_prefetch_req", 32'(req0), 0);
    cen = 1'b0; addr = 18'h401; addr_ok = 1'b1;
    @(negedge clk);
    chk("cen_hold_ok", 32'(ok0), 0);
    cen = 1'b1;
    @(negedge clk);
    chk("cen_hit_dout", 32'(dout0), 32'hBA);
    chk("cen_hit_dout_inv", 32'(dout1), 32'hBE);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 199) == 0);
      cen     = ($urandom_range(0, 3) != 0);
      addr_ok = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) addr = 18'($urandom_range(0, 47));
      flush   = ($urandom_range(0, 39) == 0);
      din     = $urandom;
      din_ok  = 1'($urandom_range(0, 1));
      we      = 1'($urandom_range(0, 1));
      @(negedge clk);
    end

    rst = 1'b0; flush = 1'b0; din_ok = 1'b0; we = 1'b0; addr_ok = 1'b0;
    @(negedge clk);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/jtframe_romcache.md
JTFRAME_ROMCACHE -- requirements
Module: jtframe_romcache

Interface
REQ-001 Parameter AW, 18, ROM address width in DW-sized units.
REQ-002 Parameter DW, 8, output data width; legal values 8, 16, 32.
REQ-003 Parameter ENTRIES, 4, cache entries of one 32-bit word each; legal values 2, 4, 8.
REQ-004 Parameter INVERT_A0, 0, when 1 and DW=8, byte lane select uses ~addr[0].
REQ-005 clk  in  1  system clock; single clock domain.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 cen  in  1  clock enable for demand-side acceptance (addr_ok sampling, data_ok/dout update).
REQ-008 addr  in  AW  requested ROM address.
REQ-009 addr_ok  in  1  addr is valid this cycle.
REQ-010 flush  in  1  invalidate all entries.
REQ-011 din  in  32  SDRAM read word.
REQ-012 din_ok  in  1  din valid.
REQ-013 we  in  1  SDRAM acknowledge that din belongs to this block's request.
REQ-014 req  out  1  SDRAM request, level.
REQ-015 addr_req  out  AW  SDRAM address, 32-bit word aligned (low log2(32/DW) bits zero).
REQ-016 data_ok  out  1  dout valid for addr sampled on the previous enabled cycle.
REQ-017 dout  out  DW  read data.

Function
REQ-018 Each entry SHALL hold valid bit, word tag (addr[AW-1:log2(32/DW)]) and 32-bit data.
REQ-019 Hit = any valid entry whose tag equals the word part of addr; lookup combinational, at most one entry matches.
REQ-020 On an enabled cycle (cen=1) with addr_ok=1 and hit, data_ok and dout SHALL update on the next clock edge (latency 1).
REQ-021 On an enabled cycle with addr_ok=0 or miss, data_ok SHALL be 0 on the next edge; dout holds its previous value.
REQ-022 Lane select: DW=8 uses {addr[1], addr[0]^INVERT_A0}, with lane 0 = din[7:0]; DW=16 uses addr[0], with 0 = din[15:0]; DW=32 uses the whole word.
REQ-023 FSM states: IDLE, FETCH. In IDLE, when addr_ok=1 and miss, the FSM SHALL go to FETCH and assert req with addr_req = word-aligned addr on the next edge.
REQ-024 In FETCH, req and addr_req SHALL stay stable until din_ok&&we, independent of cen and of addr changes.
REQ-025 On din_ok&&we in FETCH, the word SHALL be written to the entry at the round-robin pointer (pointer wraps at ENTRIES-1 to 0); req drops on the same edge; FSM returns to IDLE.
REQ-026 din_ok or we without the other, or either in IDLE, SHALL be ignored.
REQ-027 If addr changes during FETCH, the fill SHALL still complete; the new addr is evaluated in IDLE afterwards.
REQ-028 flush SHALL clear all valid bits on the next edge; a fill acknowledged in the same cycle as flush, or while flush is pending in FETCH, SHALL be discarded and not written.
REQ-029 A flush asserted together with a hit SHALL give data_ok=1 on the next edge for that access; later accesses miss.

Reset
REQ-030 rst SHALL clear all valid bits, the pointer, req, data_ok, dout and addr_req to 0, and SHALL force IDLE, including mid-FETCH; any late acknowledge after reset is ignored.

Configuration
REQ-031 Macro JTFRAME_ROMCACHE_PREFETCH_EN: when defined, after each demand fill the FSM SHALL enter a PREFETCH state and request word tag+1 (wrapping at the top of the address space), unless it is already cached.
REQ-032 With JTFRAME_ROMCACHE_PREFETCH_EN, a prefetch fill uses the next round-robin entry; a demand miss during PREFETCH waits for its completion; a hit during PREFETCH is served normally.
REQ-033 Without the macro, there is no PREFETCH state and req is asserted only for demand misses.

Verification
REQ-034 Reset, then addr=0x00010, addr_ok=1, DW=8 -> req=1, addr_req=0x00010; ack din=0xDDCCBBAA -> data_ok=1, dout=0xAA one cycle after the fill edge.
REQ-035 Then addr=0x00013 -> data_ok=1, dout=0xDD, req stays 0 (hit); with INVERT_A0=1, addr=0x00013 -> dout=0xCC.
REQ-036 ENTRIES=4: fill words 0..4 -> word 0 evicted; re-access of addr 0 -> req=1.
REQ-037 flush during FETCH, then ack -> no entry written; next access to the same addr -> req=1.
REQ-038 rst pulse mid-FETCH -> req=0 next edge; a subsequent din_ok&&we -> no write, data_ok=0.
REQ-039 PREFETCH_EN build: miss at word 0x100 -> after fill, req=1 with addr_req for word 0x101 without any addr_ok; non-EN build -> req stays 0.
